// File: rtl/decade_timer_arbiter.sv
// Round-robin sequencer that shares one decade down-counter between two requesters.
// It grants timed windows of 1-10 counts and pulses done to the owner when a window completes.
module decade_timer_arbiter #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic       clk,
  input  logic       clear,
  input  logic [1:0] req,
  input  logic [3:0] len0,
  input  logic [3:0] len1,
  output logic [1:0] grant,
  output logic       busy,
  output logic [3:0] q,
  output logic [1:0] done
);

  typedef enum logic [1:0] {S_IDLE, S_COUNT, S_DONE} state_t;

  localparam logic [7:0] LP_PRE_MAX = 8'(PRESCALE - 1);

  state_t     r_state;
  logic       r_last;
  logic [7:0] r_pre;
  logic [1:0] r_grant;
  logic       r_busy;
  logic [3:0] r_q;
  logic [1:0] r_done;

  logic       w_winner;
  logic [3:0] w_len;
  logic [3:0] w_load;
  logic       w_wrap;
  logic       w_owner_req;

  // On contention the requester not granted last wins; otherwise the lone requester wins.
  assign w_winner    = (req == 2'b11) ? ~r_last : req[1];
  assign w_len       = w_winner ? len1 : len0;
  assign w_load      = ((w_len == 4'd0) || (w_len > 4'd9)) ? 4'd9 : (w_len - 4'd1);
  assign w_wrap      = (r_pre == LP_PRE_MAX);
  assign w_owner_req = req[r_last];

  always_ff @(posedge clk) begin
    if (!clear) begin
      r_state <= S_IDLE;
      r_last  <= 1'b1;
      r_pre   <= '0;
      r_grant <= '0;
      r_busy  <= 1'b0;
      r_q     <= '0;
      r_done  <= '0;
    end else begin
      r_done <= '0;
      case (r_state)
        S_IDLE: begin
          if (|req) begin
            r_state <= S_COUNT;
            r_q     <= w_load;
            r_pre   <= '0;
            r_grant <= w_winner ? 2'b10 : 2'b01;
            r_last  <= w_winner;
            r_busy  <= 1'b1;
          end
        end
        S_COUNT: begin
          // Abort outranks completion; last keeps the aborted owner so the other side goes next.
          if (!w_owner_req) begin
            r_state <= S_IDLE;
            r_grant <= '0;
            r_busy  <= 1'b0;
            r_pre   <= '0;
          end else if (w_wrap) begin
            r_pre <= '0;
            if (r_q != 4'd0) begin
              r_q <= r_q - 4'd1;
            end else begin
              r_state        <= S_DONE;
              r_grant        <= '0;
              r_done[r_last] <= 1'b1;
            end
          end else begin
            r_pre <= r_pre + 8'd1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_grant <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign grant = r_grant;
  assign busy  = r_busy;
  assign q     = r_q;
  assign done  = r_done;

endmodule

// File: tb/tb_decade_timer_arbiter.sv
// Bench for decade_timer_arbiter: two instances (PRESCALE 1 and 2) share one stimulus stream
// and are compared every cycle against a window-level model, plus directed scenario checks.
module tb_decade_timer_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       clear;
  logic [1:0] req;
  logic [3:0] len0, len1;
  logic [1:0] grant_a, done_a, grant_b, done_b;
  logic       busy_a, busy_b;
  logic [3:0] q_a, q_b;

  int checks   = 0;
  int failures = 0;

  decade_timer_arbiter #(.PRESCALE(1)) u_a (
    .clk(clk), .clear(clear), .req(req), .len0(len0), .len1(len1),
    .grant(grant_a), .busy(busy_a), .q(q_a), .done(done_a)
  );

  decade_timer_arbiter #(.PRESCALE(2)) u_b (
    .clk(clk), .clear(clear), .req(req), .len0(len0), .len1(len1),
    .grant(grant_b), .busy(busy_b), .q(q_b), .done(done_b)
  );

  // Window-level model: owner, cycles elapsed in the window, window length.
  int unsigned m_p[2] = '{1, 2};
  int          m_owner[2];
  int unsigned m_el[2];
  int unsigned m_d[2];
  int          m_last[2];
  logic [3:0]  m_q[2];
  bit          m_done[2];

  function automatic int unsigned dur(input logic [3:0] l);
    return (l >= 4'd1 && l <= 4'd9) ? int'(l) : 10;
  endfunction

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      if (!clear) begin
        m_owner[k] = -1; m_q[k] = '0; m_last[k] = 1; m_done[k] = 0; m_el[k] = 0;
      end else if (m_done[k]) begin
        m_done[k] = 0;
      end else if (m_owner[k] >= 0) begin
        if (!req[m_owner[k]]) begin
          m_owner[k] = -1;
        end else begin
          m_el[k]++;
          if (m_el[k] == m_d[k] * m_p[k]) begin
            m_owner[k] = -1; m_done[k] = 1; m_q[k] = '0;
          end else begin
            m_q[k] = 4'(m_d[k] - 1 - m_el[k] / m_p[k]);
          end
        end
      end else if (req != 2'b00) begin
        int w;
        w = (req == 2'b11) ? 1 - m_last[k] : ((req == 2'b10) ? 1 : 0);
        m_d[k] = dur((w == 1) ? len1 : len0);
        m_owner[k] = w; m_last[k] = w; m_el[k] = 0;
        m_q[k] = 4'(m_d[k] - 1);
      end
    end
  endtask

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    logic [3:0] eg [2];
    logic [3:0] ed [2];
    logic [3:0] eb [2];
    for (int k = 0; k < 2; k++) begin
      eg[k] = (m_owner[k] >= 0) ? 4'(1 << m_owner[k]) : 4'd0;
      ed[k] = m_done[k] ? 4'(1 << m_last[k]) : 4'd0;
      eb[k] = ((m_owner[k] >= 0) || m_done[k]) ? 4'd1 : 4'd0;
    end
    check("a_grant", {2'b00, grant_a}, eg[0]);
    check("a_done",  {2'b00, done_a},  ed[0]);
    check("a_busy",  {3'b000, busy_a}, eb[0]);
    check("a_q",     q_a,              m_q[0]);
    check("b_grant", {2'b00, grant_b}, eg[1]);
    check("b_done",  {2'b00, done_b},  ed[1]);
    check("b_busy",  {3'b000, busy_b}, eb[1]);
    check("b_q",     q_b,              m_q[1]);
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic do_reset();
    clear = 1'b0;
    step();
    clear = 1'b1;
  endtask

  initial begin
    int         gcnt;
    int         dcnt;
    logic [1:0] prev;
    int         ngrants;

    // Reset held two cycles with both requesting.
    clear = 1'b0; req = 2'b11; len0 = 4'd4; len1 = 4'd3;
    step();
    check("rst_grant", {2'b00, grant_a}, 4'd0);
    step();
    check("rst_q", q_a, 4'd0);
    clear = 1'b1;
    step();
    check("rst_first_grant", {2'b00, grant_a}, 4'd1);
    check("rst_first_q", q_a, 4'd3);

    // Single window, len0=4.
    req = 2'b00;
    do_reset();
    req = 2'b01; len0 = 4'd4;
    for (int i = 0; i < 4; i++) begin
      step();
      check("single_q", q_a, 4'(3 - i));
      check("single_grant", {2'b00, grant_a}, 4'd1);
    end
    step();
    check("single_done", {2'b00, done_a}, 4'd1);
    check("single_grant_off", {2'b00, grant_a}, 4'd0);
    req = 2'b00;
    step();
    check("single_busy_off", {3'b000, busy_a}, 4'd0);
    check("single_done_off", {2'b00, done_a}, 4'd0);

    // Decade on the PRESCALE=2 instance.
    do_reset();
    req = 2'b10; len1 = 4'd0;
    gcnt = 0; dcnt = 0;
    for (int i = 0; i < 40 && dcnt == 0; i++) begin
      step();
      if (grant_b == 2'b10) gcnt++;
      if (done_b == 2'b10) dcnt++;
    end
    req = 2'b00;
    check("decade_grant_cycles", 4'(gcnt), 4'(20));
    check("decade_done_seen", 4'(dcnt), 4'd1);
    step();
    step();

    // Round-robin with both held.
    do_reset();
    req = 2'b11; len0 = 4'd2; len1 = 4'd3;
    prev = 2'b00; ngrants = 0;
    for (int i = 0; i < 30; i++) begin
      logic [1:0] was;
      was = grant_a;
      step();
      if (was == 2'b00 && grant_a != 2'b00) begin
        if (ngrants == 0) check("rr_first", {2'b00, grant_a}, 4'd1);
        else              check("rr_alt", {2'b00, grant_a}, {2'b00, ~prev});
        prev = grant_a;
        ngrants++;
      end
    end
    check("rr_count_min", (ngrants >= 5) ? 4'd1 : 4'd0, 4'd1);

    // Abort of owner 0 after two count cycles.
    req = 2'b00;
    do_reset();
    req = 2'b11; len0 = 4'd5; len1 = 4'd2;
    step();
    check("abort_grant0", {2'b00, grant_a}, 4'd1);
    step();
    step();
    req = 2'b10;
    step();
    check("abort_grant_clr", {2'b00, grant_a}, 4'd0);
    check("abort_no_done", {2'b00, done_a}, 4'd0);
    check("abort_q_hold", q_a, 4'd2);
    step();
    check("abort_next_grant", {2'b00, grant_a}, 4'd2);

    // Illegal length then reset mid-window.
    req = 2'b00;
    do_reset();
    req = 2'b01; len0 = 4'd13;
    step();
    check("illegal_q9", q_a, 4'd9);
    for (int i = 0; i < 10 && q_a != 4'd6; i++) step();
    check("illegal_q6", q_a, 4'd6);
    clear = 1'b0;
    step();
    check("midrst_q", q_a, 4'd0);
    check("midrst_grant", {2'b00, grant_a}, 4'd0);
    check("midrst_done", {2'b00, done_a}, 4'd0);
    clear = 1'b1;

    // Randomized traffic.
    req = 2'b00;
    for (int i = 0; i < 3000; i++) begin
      clear = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 15) == 0) req[0] = ~req[0];
      if ($urandom_range(0, 15) == 0) req[1] = ~req[1];
      len0 = 4'($urandom_range(0, 15));
      len1 = 4'($urandom_range(0, 15));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/decade_timer_arbiter.md
# decade_timer_arbiter

Synchronous controller that shares a single decade (mod-10) down-counter between two requesters. Each requester asks for a timed window of 1–10 counts. The block arbitrates round-robin, loads and steps the shared counter, and returns a one-cycle completion pulse to the granted requester. It sits above the team's decade counter datapath as its sequencer: the only place load, enable and terminal-count decisions are made.

## Interface
- PRESCALE, default 1: clock cycles per counter step; legal range 1–255.
- clk  input  1  single clock; all state changes on rising edge.
- clear  input  1  synchronous, active-low reset; sampled on rising clk.
- req  input  2  request per requester; held high until done or abandoned.
- len0  input  4  requested length for requester 0; sampled only at grant.
- len1  input  4  requested length for requester 1; sampled only at grant.
- grant  output  2  one-hot owner of the counter; 00 when unowned.
- busy  output  1  high while in COUNT or DONE.
- q  output  4  current shared counter value, BCD 0–9.
- done  output  2  one-cycle completion pulse to the owner.

## Operation
- Length rule: D = len when len is 1–9; D = 10 when len is 0 or 10–15.
- FSM states: IDLE, COUNT, DONE.
- IDLE:
  - If req != 00, pick a winner. On a single request, that requester wins. When both request, the winner is the requester not granted last (round-robin pointer `last`).
  - Load q = D−1 from the winner's len, clear the prescale counter, set grant to the winner, update last, go to COUNT.
  - With no request, q holds.
- COUNT:
  - Prescale counter counts 0..PRESCALE−1.
  - On its wrap with q>0, q decrements by 1.
  - On its wrap with q==0, go to DONE.
- DONE:
  - grant = 00 and done[last] = 1 for exactly this cycle; q holds 0.
  - Next state is IDLE.
- Abort: if req[owner] drops during COUNT, go to IDLE next edge.
  - No done pulse; grant clears; q holds its current value.
  - last keeps the aborted owner, so the other requester has priority next.
- Simultaneous events:
  - A req on the non-owner during COUNT or DONE is ignored until IDLE; it is not queued beyond the level of req itself.
  - If req[owner] drops on the same edge as the q==0 wrap, abort wins: no done.
- q never leaves 0–9.

## Timing
- Reset (clear=0 at an edge):
  - Next cycle: state IDLE, grant=00, done=00, busy=0, q=0, prescale=0.
  - last=1, so requester 0 wins the first contention.
- Reset mid-COUNT aborts immediately with the same values; no done is generated.
- Latency:
  - req sampled high in IDLE at edge t gives grant and busy high after t.
  - grant stays high for D×PRESCALE cycles.
  - done is high for 1 cycle, then the block spends 1 IDLE cycle.
- Back-to-back requests: minimum spacing between grants of different windows is D×PRESCALE + 2 cycles.
- len inputs are don't-care except in the IDLE cycle that grants.
- All outputs are registered; there is no combinational path from req to grant.

## Test plan
- Reset: hold clear=0 for 2 cycles with req=11. After release, next edge gives grant=01, q=D−1 from len0; grant, done and q were 0 throughout reset.
- Single window: PRESCALE=1, req=01, len0=4. Required: q = 3,2,1,0 on four grant cycles; then done=01 for one cycle; grant=00; busy low after that.
- Decade: PRESCALE=2, len1=0, req=10. Required: q = 9→0 with each value held 2 cycles; grant high 20 cycles; done=10 once.
- Round-robin: req=11 held, len0=2, len1=3, PRESCALE=1. Required grants alternate 01,10,01,… with first grant 01, each pair separated by DONE and IDLE cycles.
- Abort: len0=5, drop req[0] after 2 count cycles while req[1] is high. Required: no done[0]; grant clears; next IDLE grants 10.
- Illegal length and mid-run reset: len0=13 gives a 10-count window. Asserting clear=0 at q=6 gives q=0, grant=00, done=00 on the next edge.
